// File: rtl/input_debounce.sv
// rtl/input_debounce.sv - 2-flop synchronizer, per-key debounce counters and registered button outputs.
// Optional macro INPUT_DEBOUNCE_SOCD_EN clears opposing d-pad directions in the output stage.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] raw_keys,
    output logic        dpad_up,
    output logic        dpad_down,
    output logic        dpad_left,
    output logic        dpad_right,
    output logic        button_a,
    output logic        button_b,
    output logic        button_x,
    output logic        button_y,
    output logic        button_trig_l,
    output logic        button_trig_r,
    output logic        button_select,
    output logic        button_start,
    output logic        keys_changed
);

    localparam int NKEYS = 12;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [NKEYS-1:0]       sync1_q;
    logic [NKEYS-1:0]       sync2_q;
    logic [NKEYS-1:0]       state_q;
    logic [NKEYS-1:0]       state_d;
    logic [NKEYS-1:0]       out_q;
    logic [NKEYS-1:0]       out_d;
    logic                   keys_changed_q;
    logic                   keys_changed_d;
    logic [COUNT_WIDTH-1:0] cnt_q [NKEYS];
    logic [COUNT_WIDTH-1:0] cnt_d [NKEYS];

    // Any cycle of agreement clears the counter, so a bounce restarts the window.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        out_d = state_q;
`ifdef INPUT_DEBOUNCE_SOCD_EN
        if (state_q[0] && state_q[1]) begin
            out_d[1:0] = 2'b00;
        end
        if (state_q[2] && state_q[3]) begin
            out_d[3:2] = 2'b00;
        end
`endif
        keys_changed_d = (out_d != out_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            state_q        <= '0;
            out_q          <= '0;
            keys_changed_q <= 1'b0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q        <= raw_keys;
            sync2_q        <= sync1_q;
            state_q        <= state_d;
            out_q          <= out_d;
            keys_changed_q <= keys_changed_d;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dpad_up       = out_q[0];
    assign dpad_down     = out_q[1];
    assign dpad_left     = out_q[2];
    assign dpad_right    = out_q[3];
    assign button_a      = out_q[4];
    assign button_b      = out_q[5];
    assign button_x      = out_q[6];
    assign button_y      = out_q[7];
    assign button_trig_l = out_q[8];
    assign button_trig_r = out_q[9];
    assign button_select = out_q[10];
    assign button_start  = out_q[11];
    assign keys_changed  = keys_changed_q;

endmodule

// File: tb/tb_input_debounce.sv
// tb/tb_input_debounce.sv - scoreboard bench for input_debounce with DEBOUNCE_CYCLES=4.
module tb_input_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] raw_keys;
    logic        dpad_up, dpad_down, dpad_left, dpad_right;
    logic        button_a, button_b, button_x, button_y;
    logic        button_trig_l, button_trig_r, button_select, button_start;
    logic        keys_changed;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          exp_cyc_q [$];
    logic [12:0] exp_val_q [$];
    string       exp_tag_q [$];

    logic [12:0] obs;
    assign obs = {keys_changed, button_start, button_select, button_trig_r, button_trig_l,
                  button_y, button_x, button_b, button_a,
                  dpad_right, dpad_left, dpad_down, dpad_up};

    input_debounce #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_keys     (raw_keys),
        .dpad_up      (dpad_up),
        .dpad_down    (dpad_down),
        .dpad_left    (dpad_left),
        .dpad_right   (dpad_right),
        .button_a     (button_a),
        .button_b     (button_b),
        .button_x     (button_x),
        .button_y     (button_y),
        .button_trig_l(button_trig_l),
        .button_trig_r(button_trig_r),
        .button_select(button_select),
        .button_start (button_start),
        .keys_changed (keys_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [12:0] e;
        string       t;
        int          c;
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            c = exp_cyc_q.pop_front();
            e = exp_val_q.pop_front();
            t = exp_tag_q.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%h expected=%h", t, c, obs, e);
            end
        end
    end

    task automatic expect_at(input int off, input logic [11:0] lvl, input logic kc, input string tag);
        exp_cyc_q.push_back(cyc + off);
        exp_val_q.push_back({kc, lvl});
        exp_tag_q.push_back(tag);
    endtask

    // A stable change driven now must appear after the 7th following edge with a one-cycle pulse.
    task automatic expect_change(input logic [11:0] old_lvl, input logic [11:0] new_lvl, input string tag);
        expect_at(6, old_lvl, 1'b0, {tag, "_before"});
        expect_at(7, new_lvl, 1'b1, {tag, "_edge"});
        expect_at(8, new_lvl, 1'b0, {tag, "_after"});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        raw_keys = 12'hFFF;
        @(negedge clk);
        for (int k = 1; k <= 9; k++) expect_at(k, 12'h000, 1'b0, "reset_hold");
        step(9);
        reset = 1'b0;
        expect_change(12'h000, 12'hFFF, "reset_release");
        step(10);

        raw_keys = 12'h000;
        expect_change(12'hFFF, 12'h000, "all_release");
        step(10);
        raw_keys = 12'h010;
        expect_change(12'h000, 12'h010, "press_a");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h010, 12'h000, "release_a");
        step(10);

        for (int k = 1; k <= 12; k++) expect_at(k, 12'h000, 1'b0, "bounce");
        raw_keys = 12'h800; step(3);
        raw_keys = 12'h000; step(3);
        raw_keys = 12'h800; step(3);
        raw_keys = 12'h000; step(3);
        raw_keys = 12'h800;
        for (int k = 1; k <= 5; k++) expect_at(k, 12'h000, 1'b0, "bounce_settle");
        expect_change(12'h000, 12'h800, "start_steady");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h800, 12'h000, "release_start");
        step(10);

        raw_keys = 12'h041;
        expect_change(12'h000, 12'h041, "simul");
        expect_at(9, 12'h041, 1'b0, "simul_single");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h041, 12'h000, "simul_release");
        step(10);

        raw_keys = 12'h100;
        for (int k = 1; k <= 4; k++) expect_at(k, 12'h000, 1'b0, "midreset_pre");
        step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) expect_at(k, 12'h000, 1'b0, "midreset_post");
        expect_change(12'h000, 12'h100, "midreset_accept");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h100, 12'h000, "midreset_release");
        step(10);

`ifdef INPUT_DEBOUNCE_SOCD_EN
        raw_keys = 12'h003;
        for (int k = 6; k <= 8; k++) expect_at(k, 12'h000, 1'b0, "socd_updown");
        step(10);
        raw_keys = 12'h001;
        expect_change(12'h000, 12'h001, "socd_drop_down");
        step(10);
        raw_keys = 12'h00D;
        for (int k = 6; k <= 8; k++) expect_at(k, 12'h001, 1'b0, "socd_leftright");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h001, 12'h000, "socd_release");
        step(10);
`else
        raw_keys = 12'h003;
        expect_change(12'h000, 12'h003, "updown_both");
        step(10);
        raw_keys = 12'h001;
        expect_change(12'h003, 12'h001, "drop_down");
        step(10);
        raw_keys = 12'h00D;
        expect_change(12'h001, 12'h00D, "leftright_both");
        step(10);
        raw_keys = 12'h000;
        expect_change(12'h00D, 12'h000, "dpad_release");
        step(10);
`endif

        for (int k = 0; k < 50 && exp_cyc_q.size() > 0; k++) @(negedge clk);
        total++;
        assert (exp_cyc_q.size() == 0) else begin
            bad++;
            $error("FAIL drain observed=%0d expected=0", exp_cyc_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
